apb3_master_bridge: RTL

//  APB3 requester. Turns a valid/ready command stream into APB3 SETUP/ACCESS transfers.

---
 rtl/apb3_master_bridge_if.sv | 49 ++++
 rtl/apb3_master_bridge.sv | 133 +++++++++++++
 2 files changed

// File: rtl/apb3_master_bridge_if.sv
// Bundle of the command stream, response stream and APB3 bus signals for apb3_master_bridge.
// The "master" modport is the bridge's view. The "slave" modport is the view of the
// environment: the local controller and the APB3 slaves.
interface apb3_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    // Command stream (local controller -> bridge)
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // Response stream (bridge -> local controller)
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // APB3 requester side
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb3_master_bridge.sv
// APB3 requester bridge. It accepts one valid/ready command, runs a single APB3
// SETUP/ACCESS transfer, and returns the completion on a valid/ready response stream.
// A watchdog aborts an ACCESS phase in which pready stays low for TIMEOUT cycles.
module apb3_master_bridge #(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 pclk,
    input  logic                 preset,
    apb3_master_bridge_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // The watchdog value seen in the last ACCESS cycle before an abort.
    // ACCESS cycle k sees r_wdog == k-1, so the abort decision falls on cycle TIMEOUT.
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    state_t            r_state;
    logic [15:0]       r_wdog;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;

    // Saturating increment, so the counter can never wrap back to a small value.
    function automatic logic [15:0] wdog_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            wdog_inc = value;
        end else begin
            wdog_inc = value + 16'd1;
        end
    endfunction

    // Transfer FSM. It drives all APB and response outputs from registers.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state       <= ST_IDLE;
            r_wdog        <= 16'd0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= {ADDR_W{1'b0}};
            r_pwdata      <= {DATA_W{1'b0}};
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= {DATA_W{1'b0}};
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // cmd_ready is high in IDLE, so cmd_valid alone completes the handshake.
                    if (bus.cmd_valid) begin
                        r_pwrite  <= bus.cmd_write;
                        r_paddr   <= bus.cmd_addr;
                        r_pwdata  <= bus.cmd_wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= ST_SETUP;
                    end else begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_wdog    <= 16'd0;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready takes priority, so a completion on the expiry cycle is
                    // treated as normal and not as a timeout.
                    if (bus.pready) begin
                        r_rsp_rdata   <= r_pwrite ? {DATA_W{1'b0}} : bus.prdata;
                        r_rsp_err     <= bus.pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= ST_RESP;
                    end else if (r_wdog == WDOG_LAST) begin
                        r_rsp_rdata   <= {DATA_W{1'b0}};
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= ST_RESP;
                    end else begin
                        r_wdog <= wdog_inc(r_wdog);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = (r_state == ST_IDLE);
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.pwrite      = r_pwrite;
    assign bus.paddr       = r_paddr;
    assign bus.pwdata      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule
